regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//   Owns the single write port (En/RdestRegLoc/Load) of the 16x16 register file.
//   Shares it between two requesters (A = ALU writeback, B = memory load) with
//   valid/ready handshakes and round-robin arbitration.
//   After reset, or on request, it zeroes every register by walking addresses.
//   Sits between the writeback stage and RegFile; read ports are not touched.
// PARAMETERS
//   DATA_W    16  width of register data
//   ADDR_W    4   width of register address
//   NUM_REGS  16  registers cleared by the walk (<= 2**ADDR_W)
// PORTS
//   Clk         in   1       clock, all logic on rising edge
//   Rst         in   1       reset, synchronous, active-high
//   ReqA_Valid  in   1       A has a write pending
//   ReqA_Addr   in   ADDR_W  A destination register
//   ReqA_Data   in   DATA_W  A write data
//   ReqA_Ready  out  1       A transfer accepted this edge if Valid&&Ready
//   ReqB_Valid  in   1       B has a write pending
//   ReqB_Addr   in   ADDR_W  B destination register
//   ReqB_Data   in   DATA_W  B write data
//   ReqB_Ready  out  1       B transfer accepted this edge if Valid&&Ready
//   ClearReq    in   1       pulse/level: start a full clear walk
//   RfEn        out  1       to RegFile En (registered)
//   RfAddr      out  ADDR_W  to RegFile RdestRegLoc (registered)
//   RfLoad      out  DATA_W  to RegFile Load (registered)
//   Busy        out  1       high while clear walk in progress
//   LastGrantB  out  1       1 = most recent grant went to B
// BEHAVIOUR
//   Reset (Rst=1 at edge): state=CLEAR, cnt=0, RfEn=0, RfAddr=0, RfLoad=0,
//     Busy=1, LastGrantB=1 (so A wins the first tie). Rst mid-walk restarts at 0.
//   States: CLEAR, SERVE.
//   CLEAR: each edge registers RfEn=1, RfAddr=cnt, RfLoad=0, cnt<=cnt+1.
//     Edge issuing cnt==NUM_REGS-1 moves to SERVE, cnt<=0. Walk = NUM_REGS
//     consecutive RfEn cycles. Both Ready=0 throughout. ClearReq ignored.
//   SERVE: Busy=0. Ready is combinational from state, Valids, ClearReq, LastGrantB:
//     ClearReq=1 -> both Ready=0; next state CLEAR (cnt=0).
//     only A valid -> ReqA_Ready=1; only B valid -> ReqB_Ready=1.
//     both valid -> grant the side not in LastGrantB; other Ready=0.
//     Ready never high for a side whose Valid is low.
//   Accept at edge N: RfEn=1, RfAddr/RfLoad=granted Addr/Data, LastGrantB updated;
//     RegFile commits at edge N+1. No accept -> RfEn=0 at edge N (one-cycle pulse).
//   Throughput: one write per cycle, back-to-back accepts allowed.
//   Same address from A and B: serialised by round-robin; later grant wins.
//   Requesters hold Addr/Data stable while Valid&&!Ready; arbiter holds no queue.
//   Last write issued in SERVE completes even if CLEAR entered next cycle.
//   RfLoad is 0 whenever RfEn=0.
// TESTING
//   T1 Rst=1 two edges, release -> 16 cycles RfEn=1, RfAddr 0..15, RfLoad=0,
//      Busy=1 then Busy=0, both Ready=0 during walk.
//   T2 A only: Valid, Addr=3, Data=16'h1234 -> Ready=1, next cycle RfEn=1,
//      RfAddr=3, RfLoad=16'h1234; following cycle RfEn=0.
//   T3 A,B both valid 4 cycles (A:5/0x00AA, B:9/0x00BB) -> grants A,B,A,B;
//      RfAddr 5,9,5,9; LastGrantB toggles 0,1,0,1.
//   T4 B valid + ClearReq=1 same cycle -> ReqB_Ready=0, 16-cycle walk, then B
//      accepted; RfAddr=9 RfLoad=0x00BB after walk ends.
//   T5 Rst pulsed when walk at RfAddr=7 -> RfEn=0 at reset edge, walk restarts
//      at 0 and still emits 16 addresses.
//   T6 A valid, Ready forced low by B priority -> A Addr/Data held, accepted next
//      cycle; no write lost or duplicated (scoreboard vs. RegFile contents).

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Requester handshakes, clear request and RegFile write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              reqa_valid;
    logic [ADDR_W-1:0] reqa_addr;
    logic [DATA_W-1:0] reqa_data;
    logic              reqa_ready;

    logic              reqb_valid;
    logic [ADDR_W-1:0] reqb_addr;
    logic [DATA_W-1:0] reqb_data;
    logic              reqb_ready;

    logic              clear_req;

    logic              rf_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_load;
    logic              busy;
    logic              last_grant_b;

    // Requester / writeback side.
    modport master (
        output reqa_valid, reqa_addr, reqa_data,
        output reqb_valid, reqb_addr, reqb_data,
        output clear_req,
        input  reqa_ready, reqb_ready,
        input  rf_en, rf_addr, rf_load, busy, last_grant_b
    );

    // Arbiter side.
    modport slave (
        input  reqa_valid, reqa_addr, reqa_data,
        input  reqb_valid, reqb_addr, reqb_data,
        input  clear_req,
        output reqa_ready, reqb_ready,
        output rf_en, rf_addr, rf_load, busy, last_grant_b
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin owner of the RegFile write port with a clear walk.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    regfile_write_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rf_en;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_load;
    logic              r_last_grant_b;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_rf_en_nxt;
    logic [ADDR_W-1:0] w_rf_addr_nxt;
    logic [DATA_W-1:0] w_rf_load_nxt;
    logic              w_last_grant_b_nxt;
    logic              w_ready_a;
    logic              w_ready_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_CLEAR;
            r_cnt          <= '0;
            r_rf_en        <= 1'b0;
            r_rf_addr      <= '0;
            r_rf_load      <= '0;
            r_last_grant_b <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rf_en        <= w_rf_en_nxt;
            r_rf_addr      <= w_rf_addr_nxt;
            r_rf_load      <= w_rf_load_nxt;
            r_last_grant_b <= w_last_grant_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_rf_en_nxt        = 1'b0;
        w_rf_addr_nxt      = '0;
        w_rf_load_nxt      = '0;
        w_last_grant_b_nxt = r_last_grant_b;
        w_ready_a          = 1'b0;
        w_ready_b          = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                w_rf_en_nxt   = 1'b1;
                w_rf_addr_nxt = r_cnt;
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_SERVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + ADDR_W'(1);
                end
            end

            ST_SERVE: begin
                if (bus.clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else begin
                    // On a tie, the side that did not win last time goes first.
                    w_ready_a = bus.reqa_valid && (!bus.reqb_valid || r_last_grant_b);
                    w_ready_b = bus.reqb_valid && (!bus.reqa_valid || !r_last_grant_b);
                end

                if (w_ready_a) begin
                    w_rf_en_nxt        = 1'b1;
                    w_rf_addr_nxt      = bus.reqa_addr;
                    w_rf_load_nxt      = bus.reqa_data;
                    w_last_grant_b_nxt = 1'b0;
                end else if (w_ready_b) begin
                    w_rf_en_nxt        = 1'b1;
                    w_rf_addr_nxt      = bus.reqb_addr;
                    w_rf_load_nxt      = bus.reqb_data;
                    w_last_grant_b_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.reqa_ready   = w_ready_a;
    assign bus.reqb_ready   = w_ready_b;
    assign bus.rf_en        = r_rf_en;
    assign bus.rf_addr      = r_rf_addr;
    assign bus.rf_load      = r_rf_load;
    assign bus.busy         = (r_state == ST_CLEAR);
    assign bus.last_grant_b = r_last_grant_b;

endmodule
`default_nettype wire
